// File: rtl/lap_timer.sv
// Stopwatch datapath: centisecond BCD time base, lap capture into a circular
// buffer with combinational readback, and a sequenced lap-memory clear.
module lap_timer #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_DIV  = CLK_HZ / 100,
    parameter int LAP_DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [10:0]                  state,
    input  logic [$clog2(LAP_DEPTH)-1:0] rd_index,
    output logic [23:0]                  time_bcd,
    output logic [23:0]                  lap_bcd,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         lap_valid,
    output logic [23:0]                  rd_data,
    output logic                         reg_busy
);

    localparam int AW = $clog2(LAP_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(TICK_DIV);

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(LAP_DEPTH);

    localparam int B_RUN       = 2;
    localparam int B_PRE_PAUSE = 3;
    localparam int B_RETRIEVE  = 5;
    localparam int B_SAVE      = 6;
    localparam int B_RESET     = 8;

    // Increment mm:ss.cc by one centisecond; seconds and minutes tens wrap at 5.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  d;
        logic [3:0]  lim;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d   = t[4*i +: 4];
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (d >= lim) begin
                    d = 4'd0;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    logic          one_hot;
    logic          run;
    logic          ret_v;
    logic          rst_v;
    logic          tick;
    logic          capture;
    logic          first_clr;

    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   time_q, time_d;
    logic [23:0]   lap_q, lap_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic          ret_q;
    logic          lap_valid_q;
    logic [23:0]   entry_q [LAP_DEPTH];
    logic [AW-1:0] rd_ptr;

    // A malformed (non-one-hot) state vector disables every action.
    assign one_hot = (state != '0) && ((state & (state - 11'd1)) == '0);
    assign run     = one_hot & (state[B_RUN] | state[B_PRE_PAUSE] |
                                state[B_RETRIEVE] | state[B_SAVE]);
    assign ret_v   = one_hot & state[B_RETRIEVE];
    assign rst_v   = one_hot & state[B_RESET];

    assign tick      = run & (presc_q == TICK_LAST);
    assign capture   = ret_v & ~ret_q;
    assign first_clr = rst_v & (clr_cnt_q == '0);
    assign reg_busy  = rst_v & (clr_cnt_q != DEPTH_CNT);

    always_comb begin
        presc_d  = presc_q;
        time_d   = time_q;
        lap_d    = lap_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        if (first_clr) begin
            presc_d  = '0;
            time_d   = '0;
            lap_d    = '0;
            count_d  = '0;
            wr_ptr_d = '0;
        end else begin
            if (run) begin
                presc_d = tick ? '0 : presc_q + PW'(1);
            end
            if (tick) begin
                time_d = bcd_inc(time_q);
            end
            // Capture takes the pre-tick time so a coincident tick is not seen.
            if (capture) begin
                lap_d    = time_q;
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (count_q != DEPTH_CNT) begin
                    count_d = count_q + CW'(1);
                end
            end
        end
    end

    always_comb begin
        clr_cnt_d = clr_cnt_q;
        if (!rst_v) begin
            clr_cnt_d = '0;
        end else if (clr_cnt_q != DEPTH_CNT) begin
            clr_cnt_d = clr_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            time_q      <= '0;
            lap_q       <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            clr_cnt_q   <= '0;
            ret_q       <= 1'b0;
            lap_valid_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            time_q      <= time_d;
            lap_q       <= lap_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            clr_cnt_q   <= clr_cnt_d;
            ret_q       <= ret_v;
            lap_valid_q <= capture;
        end
    end

    // Clear and capture never coincide: RESET and RETRIEVE are distinct one-hot bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (reg_busy) begin
            entry_q[clr_cnt_q[AW-1:0]] <= '0;
        end else if (capture) begin
            entry_q[wr_ptr_q] <= time_q;
        end
    end

    assign rd_ptr  = wr_ptr_q - AW'(1) - rd_index;
    assign rd_data = ({1'b0, rd_index} < count_q) ? entry_q[rd_ptr] : '0;

    assign time_bcd  = time_q;
    assign lap_bcd   = lap_q;
    assign lap_count = count_q;
    assign lap_valid = lap_valid_q;

endmodule

// File: tb/tb_lap_timer.sv
// Directed bench for lap_timer with TICK_DIV=4 and LAP_DEPTH=4.
module tb_lap_timer;

    localparam logic [10:0] S_IDLE      = 11'h001;
    localparam logic [10:0] S_PRE_START = 11'h002;
    localparam logic [10:0] S_RUN       = 11'h004;
    localparam logic [10:0] S_PRE_PAUSE = 11'h008;
    localparam logic [10:0] S_PAUSE     = 11'h010;
    localparam logic [10:0] S_RETRIEVE  = 11'h020;
    localparam logic [10:0] S_SAVE      = 11'h040;
    localparam logic [10:0] S_PRE_RESET = 11'h080;
    localparam logic [10:0] S_RESET     = 11'h100;
    localparam logic [10:0] S_PRE_CLEAR = 11'h200;
    localparam logic [10:0] S_CLEAR     = 11'h400;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [10:0] state;
    logic [1:0]  rd_index;
    logic [23:0] time_bcd;
    logic [23:0] lap_bcd;
    logic [2:0]  lap_count;
    logic        lap_valid;
    logic [23:0] rd_data;
    logic        reg_busy;

    int tests = 0;
    int fails = 0;

    lap_timer #(
        .CLK_HZ   (400),
        .TICK_DIV (4),
        .LAP_DEPTH(4)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .state    (state),
        .rd_index (rd_index),
        .time_bcd (time_bcd),
        .lap_bcd  (lap_bcd),
        .lap_count(lap_count),
        .lap_valid(lap_valid),
        .rd_data  (rd_data),
        .reg_busy (reg_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge: holds st for n rising edges.
    task automatic run_cycles(input logic [10:0] st, input int n);
        state = st;
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if ({time_bcd, lap_bcd, lap_count, lap_valid, rd_data, reg_busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: time=%h lap=%h cnt=%0d valid=%b rd=%h busy=%b, want all 0",
                     time_bcd, lap_bcd, lap_count, lap_valid, rd_data, reg_busy);
        end
        state = S_RESET;
        #1;
        tests++;
        if (reg_busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_busy_follows_state: busy=%b, want 1", reg_busy);
        end
        state = S_IDLE;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        tests++;
        if (time_bcd !== 24'h000000 || lap_count !== 3'd0) begin
            fails++;
            $display("FAIL post_reset_idle: time=%h cnt=%0d, want 000000/0", time_bcd, lap_count);
        end
    endtask

    task automatic test_run_pause;
        run_cycles(S_RUN, 400);
        tests++;
        if (time_bcd !== 24'h000100) begin
            fails++;
            $display("FAIL run_400: time=%h, want 000100", time_bcd);
        end
        run_cycles(S_PAUSE, 50);
        tests++;
        if (time_bcd !== 24'h000100) begin
            fails++;
            $display("FAIL pause_hold: time=%h, want 000100", time_bcd);
        end
    endtask

    task automatic test_hold_states;
        logic [10:0] hs [5];
        hs[0] = S_IDLE;
        hs[1] = S_PRE_START;
        hs[2] = S_PRE_RESET;
        hs[3] = S_PRE_CLEAR;
        hs[4] = S_CLEAR;
        for (int i = 0; i < 5; i++) begin
            run_cycles(hs[i], 6);
            tests++;
            if (time_bcd !== 24'h000100 || lap_count !== 3'd0 || reg_busy !== 1'b0) begin
                fails++;
                $display("FAIL hold_state_%0d: time=%h cnt=%0d busy=%b, want 000100/0/0",
                         i, time_bcd, lap_count, reg_busy);
            end
        end
    endtask

    task automatic test_run_states;
        run_cycles(S_PRE_PAUSE, 4);
        tests++;
        if (time_bcd !== 24'h000101) begin
            fails++;
            $display("FAIL pre_pause_runs: time=%h, want 000101", time_bcd);
        end
        run_cycles(S_SAVE, 4);
        tests++;
        if (time_bcd !== 24'h000102) begin
            fails++;
            $display("FAIL save_runs: time=%h, want 000102", time_bcd);
        end
    endtask

    task automatic test_invalid_state;
        int pulses;
        run_cycles(S_RUN | S_PAUSE, 8);
        tests++;
        if (time_bcd !== 24'h000102) begin
            fails++;
            $display("FAIL multi_hot_no_run: time=%h, want 000102", time_bcd);
        end
        pulses = 0;
        state  = S_RUN | S_RETRIEVE;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (lap_valid === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0 || lap_count !== 3'd0 || time_bcd !== 24'h000102) begin
            fails++;
            $display("FAIL multi_hot_no_capture: pulses=%0d cnt=%0d time=%h, want 0/0/000102",
                     pulses, lap_count, time_bcd);
        end
        state = S_RESET | S_IDLE;
        #1;
        tests++;
        if (reg_busy !== 1'b0) begin
            fails++;
            $display("FAIL multi_hot_no_busy: busy=%b, want 0", reg_busy);
        end
        repeat (3) @(negedge clock);
        tests++;
        if (time_bcd !== 24'h000102) begin
            fails++;
            $display("FAIL multi_hot_no_clear: time=%h, want 000102", time_bcd);
        end
        state = S_IDLE;
        @(negedge clock);
    endtask

    task automatic test_wrap;
        state = S_IDLE;
        force dut.time_q = 24'h595999;
        @(negedge clock);
        release dut.time_q;
        @(negedge clock);
        tests++;
        if (time_bcd !== 24'h595999) begin
            fails++;
            $display("FAIL preload: time=%h, want 595999", time_bcd);
        end
        run_cycles(S_RUN, 4);
        tests++;
        if (time_bcd !== 24'h000000 || lap_count !== 3'd0) begin
            fails++;
            $display("FAIL wrap_5959: time=%h cnt=%0d, want 000000/0", time_bcd, lap_count);
        end
    endtask

    task automatic test_lap_hold;
        int pulses;
        run_cycles(S_RUN, 20);
        tests++;
        if (time_bcd !== 24'h000005) begin
            fails++;
            $display("FAIL run_to_005: time=%h, want 000005", time_bcd);
        end
        pulses = 0;
        state  = S_RETRIEVE;
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            if (lap_valid === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL lap_valid_once: pulses=%0d, want 1", pulses);
        end
        tests++;
        if (lap_bcd !== 24'h000005 || lap_count !== 3'd1) begin
            fails++;
            $display("FAIL lap_value: lap=%h cnt=%0d, want 000005/1", lap_bcd, lap_count);
        end
        rd_index = 2'd0;
        #1;
        tests++;
        if (rd_data !== 24'h000005) begin
            fails++;
            $display("FAIL rd_idx0_single: rd=%h, want 000005", rd_data);
        end
        rd_index = 2'd1;
        #1;
        tests++;
        if (rd_data !== 24'h000000) begin
            fails++;
            $display("FAIL rd_beyond_count: rd=%h, want 000000", rd_data);
        end
        rd_index = 2'd0;
        state    = S_PAUSE;
        @(negedge clock);
    endtask

    task automatic test_circular;
        logic [23:0] exp_rd [4];
        exp_rd[0] = 24'h000006;
        exp_rd[1] = 24'h000005;
        exp_rd[2] = 24'h000004;
        exp_rd[3] = 24'h000003;
        state   = S_IDLE;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_cycles(S_RUN, 4);
        for (int k = 0; k < 6; k++) begin
            run_cycles(S_RETRIEVE, 1);
            run_cycles(S_RUN, 3);
        end
        state = S_PAUSE;
        @(negedge clock);
        tests++;
        if (lap_count !== 3'd4 || lap_bcd !== 24'h000006) begin
            fails++;
            $display("FAIL circ_count: cnt=%0d lap=%h, want 4/000006", lap_count, lap_bcd);
        end
        for (int r = 0; r < 4; r++) begin
            rd_index = 2'(r);
            #1;
            tests++;
            if (rd_data !== exp_rd[r]) begin
                fails++;
                $display("FAIL circ_rd_idx%0d: rd=%h, want %h", r, rd_data, exp_rd[r]);
            end
        end
        rd_index = 2'd0;
        @(negedge clock);
    endtask

    task automatic test_clear;
        logic [5:0] pat;
        state = S_RESET;
        for (int i = 0; i < 6; i++) begin
            #1;
            pat[i] = reg_busy;
            @(negedge clock);
        end
        tests++;
        if (pat !== 6'b001111) begin
            fails++;
            $display("FAIL clear_busy_pattern: got %b, want 001111", pat);
        end
        tests++;
        if ({time_bcd, lap_bcd, lap_count, lap_valid, rd_data} !== '0) begin
            fails++;
            $display("FAIL clear_outputs: time=%h lap=%h cnt=%0d valid=%b rd=%h, want all 0",
                     time_bcd, lap_bcd, lap_count, lap_valid, rd_data);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (dut.entry_q[i] !== 24'h000000) begin
                fails++;
                $display("FAIL clear_entry%0d: got %h, want 000000", i, dut.entry_q[i]);
            end
        end
        state = S_IDLE;
        @(negedge clock);
    endtask

    task automatic test_clear_abort;
        logic [5:0] pat;
        run_cycles(S_RUN, 8);
        run_cycles(S_RETRIEVE, 1);
        run_cycles(S_PAUSE, 1);
        tests++;
        if (lap_count !== 3'd1 || lap_bcd !== 24'h000002) begin
            fails++;
            $display("FAIL abort_setup: cnt=%0d lap=%h, want 1/000002", lap_count, lap_bcd);
        end
        state = S_RESET;
        repeat (2) @(negedge clock);
        state = S_IDLE;
        repeat (3) @(negedge clock);
        tests++;
        if (dut.clr_cnt_q !== 3'd0 || reg_busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_clr_cnt: clr_cnt=%0d busy=%b, want 0/0", dut.clr_cnt_q, reg_busy);
        end
        state = S_RESET;
        for (int i = 0; i < 6; i++) begin
            #1;
            pat[i] = reg_busy;
            @(negedge clock);
        end
        tests++;
        if (pat !== 6'b001111) begin
            fails++;
            $display("FAIL reenter_busy_pattern: got %b, want 001111", pat);
        end
        state = S_IDLE;
        @(negedge clock);
    endtask

    task automatic test_async_reset;
        run_cycles(S_RUN, 20);
        run_cycles(S_RETRIEVE, 1);
        run_cycles(S_RUN, 5);
        tests++;
        if (lap_bcd !== 24'h000005 || time_bcd !== 24'h000006 || lap_count !== 3'd1) begin
            fails++;
            $display("FAIL async_setup: lap=%h time=%h cnt=%0d, want 000005/000006/1",
                     lap_bcd, time_bcd, lap_count);
        end
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({time_bcd, lap_bcd, lap_count, lap_valid, rd_data, reg_busy} !== '0) begin
            fails++;
            $display("FAIL async_reset: time=%h lap=%h cnt=%0d valid=%b rd=%h busy=%b, want all 0",
                     time_bcd, lap_bcd, lap_count, lap_valid, rd_data, reg_busy);
        end
        @(negedge clock);
        state   = S_IDLE;
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        reset_n  = 1'b0;
        state    = S_IDLE;
        rd_index = 2'd0;
        test_reset();
        test_run_pause();
        test_hold_states();
        test_run_states();
        test_invalid_state();
        test_wrap();
        test_lap_hold();
        test_circular();
        test_clear();
        test_clear_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter TICK_DIV, default CLK_HZ/100, clock cycles per centisecond tick; legal range is 2 or greater.
REQ-003 SHALL have parameter LAP_DEPTH, default 8, number of lap entries; legal values are powers of two from 2 to 16.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clock  in  1  system clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 state  in  11  one-hot control state: bit0 IDLE, 1 PRE_START, 2 RUN, 3 PRE_PAUSE, 4 PAUSE, 5 RETRIEVE, 6 SAVE, 7 PRE_RESET, 8 RESET, 9 PRE_CLEAR, 10 CLEAR.
REQ-008 rd_index  in  log2(LAP_DEPTH)  lap entry select, 0 = most recent lap.
REQ-009 time_bcd  out  24  running time as BCD digits {m1,m0,s1,s0,c1,c0}, format mm:ss.cc.
REQ-010 lap_bcd  out  24  most recently captured lap time, same format.
REQ-011 lap_count  out  log2(LAP_DEPTH)+1  number of valid stored laps.
REQ-012 lap_valid  out  1  one-cycle pulse on lap capture.
REQ-013 rd_data  out  24  lap entry selected by rd_index, combinational read; reads 0 when rd_index >= lap_count.
REQ-014 reg_busy  out  1  clear in progress; feeds control stimulus bit 0.

Function
REQ-015 SHALL define run = state[RUN] | state[PRE_PAUSE] | state[RETRIEVE] | state[SAVE], valid only when state is exactly one-hot; any non-one-hot state gives run = 0, no capture and no clear.
REQ-016 SHALL keep a prescaler that counts 0..TICK_DIV-1 while run = 1 and emits a tick on the wrap cycle; the prescaler holds its value while run = 0.
REQ-017 SHALL advance time_bcd by 0.01 s on each tick, with c0 and s0 carrying at 9 to 0, c1 carrying at 9, and s1 carrying at 5.
REQ-018 SHALL wrap time_bcd from 59:59.99 to 00:00.00 with no other side effect.
REQ-019 SHALL register state[RETRIEVE] and capture a lap only on its rising edge (the first RETRIEVE cycle); holding RETRIEVE captures exactly once.
REQ-020 SHALL write the lap value as time_bcd in the capture cycle, including any tick on that same edge not yet applied, i.e. the pre-update value.
REQ-021 On capture SHALL update lap_bcd, write the entry at the write pointer, advance the pointer mod LAP_DEPTH, and pulse lap_valid one cycle later, aligned with lap_bcd updating.
REQ-022 SHALL increment lap_count on capture, saturating at LAP_DEPTH; when full, a new lap overwrites the oldest entry (circular buffer).
REQ-023 SHALL map rd_index r to entry (wr_ptr-1-r) mod LAP_DEPTH.
REQ-024 SHALL keep a clear counter clr_cnt that is held at 0 whenever state[RESET] = 0 and increments by 1 each cycle in RESET until it reaches LAP_DEPTH, then holds.
REQ-025 SHALL drive reg_busy combinationally as state[RESET] & (clr_cnt != LAP_DEPTH), so it is high in the first RESET cycle.
REQ-026 While reg_busy is high, SHALL zero entry clr_cnt each cycle.
REQ-027 In the first RESET cycle, SHALL zero time_bcd, lap_bcd, lap_count, the write pointer and the prescaler.
REQ-028 A RESET dwell SHALL last exactly LAP_DEPTH+1 cycles with a compliant control FSM, and SHALL abort cleanly if state leaves RESET early: clr_cnt returns to 0 and the next RESET entry restarts the clear.
REQ-029 States IDLE, PRE_START, PAUSE, PRE_RESET, PRE_CLEAR and CLEAR SHALL hold all values unchanged.

Reset
REQ-030 On reset_n low, SHALL asynchronously clear time_bcd, lap_bcd, all entries, lap_count, the write pointer, the prescaler, clr_cnt, the RETRIEVE history register and lap_valid to 0.
REQ-031 reg_busy SHALL follow REQ-025 during reset, i.e. high if state[RESET] = 1.
REQ-032 Operation SHALL resume on the first rising clock edge after reset_n deasserts.

Verification (TICK_DIV=4, LAP_DEPTH=4)
REQ-033 Bench SHALL drive RUN for 400 cycles -> time_bcd = 00:01.00 (BCD 0x000100); then PAUSE for 50 cycles -> time_bcd is unchanged.
REQ-034 Bench SHALL preload time_bcd to 59:59.99, then RUN for 4 cycles -> time_bcd = 00:00.00 and lap_count is unchanged.
REQ-035 Bench SHALL hold RETRIEVE for 10 cycles at time 00:00.05 -> one lap_valid pulse, lap_bcd = 0x000005, and lap_count = 1.
REQ-036 Bench SHALL capture 6 laps at 0.01 to 0.06 -> lap_count = 4, rd_data at index 0 = 0x000006, index 3 = 0x000003.
REQ-037 Bench SHALL enter RESET -> reg_busy is high for exactly 4 cycles including the entry cycle, then low; all outputs read 0.
REQ-038 Bench SHALL leave RESET after 2 cycles and later re-enter -> reg_busy is high for a full 4 cycles.
REQ-039 Bench SHALL assert reset_n low mid-RUN -> all outputs are 0 immediately, without waiting for a clock edge.
